// File: rtl/minsoc_ram_loader.sv
// rtl/minsoc_ram_loader.sv - byte stream to Wishbone RAM boot loader
//
// Packs a big-endian byte stream into 32-bit words and writes each word with a
// single Wishbone write to consecutive word addresses starting at base_adr.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   ld_start_i, ld_len_i        start pulse and word count (captured on start)
//   byte_i/byte_valid_i/byte_ready_o  byte stream handshake
//   busy_o, done_o, err_o       status to the boot controller
//   wb_*_o, wb_ack_i, wb_err_i  Wishbone write master (wb_dat_i unused)
module minsoc_ram_loader #(
    parameter int unsigned adr_width   = 13,
    parameter logic [31:0] base_adr    = 32'h0000_0000,
    parameter int unsigned ack_timeout = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 ld_start_i,
    input  logic [adr_width:0]   ld_len_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    localparam logic [7:0]         tmo_limit = 8'(ack_timeout);
    localparam logic [adr_width:0] cnt_one   = {{adr_width{1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [adr_width:0]   len_q, len_d;
    logic [adr_width:0]   word_cnt_q, word_cnt_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [7:0]           tmo_q, tmo_d;
    logic [31:0]          word_q, word_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic                 byte_ready_q, byte_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 cyc_q, cyc_d;

    logic                 accept;
    logic [adr_width:0]   word_cnt_inc;
    logic [7:0]           tmo_inc;
    logic [31:0]          word_next;
    logic                 unused_dat;

    // Write-only master: read data is intentionally ignored.
    assign unused_dat = ^wb_dat_i;

    assign accept       = byte_valid_i & byte_ready_q;
    assign word_cnt_inc = word_cnt_q + cnt_one;
    assign tmo_inc      = tmo_q + 8'd1;
    // Shifting left on every byte leaves byte 0 in [31:24] after four bytes.
    assign word_next    = {word_q[23:0], byte_i};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        word_d     = word_q;
        adr_d      = adr_q;
        dat_d      = dat_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (ld_start_i) begin
                    len_d      = ld_len_i;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    state_d    = (ld_len_i == '0) ? S_DONE : S_COLLECT;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    word_d     = word_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Address and data are latched once so they stay
                        // stable for however long the slave takes to answer.
                        adr_d   = base_adr + 32'({word_cnt_q, 2'b00});
                        dat_d   = word_next;
                        tmo_d   = '0;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wb_err_i) begin
                    state_d = S_ERROR;
                end else if (wb_ack_i) begin
                    word_cnt_d = word_cnt_inc;
                    state_d    = (word_cnt_inc == len_q) ? S_DONE : S_COLLECT;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == tmo_limit) begin
                        state_d = S_ERROR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status and bus controls are registered from the next state so they
        // line up with the state they describe.
        byte_ready_d = (state_d == S_COLLECT);
        busy_d       = (state_d == S_COLLECT) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERROR);
        cyc_d        = (state_d == S_WRITE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            word_q       <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cyc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_q        <= tmo_d;
            word_q       <= word_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cyc_q        <= cyc_d;
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = cyc_q;
    assign wb_sel_o     = {4{cyc_q}};

endmodule

// File: tb/tb_minsoc_ram_loader.sv
// tb/tb_minsoc_ram_loader.sv - self-checking bench for minsoc_ram_loader
module tb_minsoc_ram_loader;

    localparam int          AW   = 6;
    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ld_start;
    logic [AW:0] ld_len;
    logic [7:0]  byte_d;
    logic        byte_valid;
    logic        byte_ready, busy, done, err;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, berr;

    minsoc_ram_loader #(.adr_width(AW), .base_adr(BASE), .ack_timeout(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .ld_start_i(ld_start), .ld_len_i(ld_len),
        .byte_i(byte_d), .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
        .busy_o(busy), .done_o(done), .err_o(err),
        .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_sel_o(sel),
        .wb_we_o(we), .wb_cyc_o(cyc), .wb_stb_o(stb),
        .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(berr)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // RAM slave model: acks after slv_delay wait cycles, raises err on write
    // number slv_err_at (ack may be high at the same time), or stays silent.
    logic        slv_clr, slv_mute;
    int          slv_delay, slv_err_at;
    int          slv_wait = 0;
    int          slv_idx = 0;
    logic [31:0] mem [0:63];
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];

    assign ack  = stb && !slv_mute && (slv_wait >= slv_delay);
    assign berr = stb && (slv_idx == slv_err_at);

    always @(posedge clk) begin
        if (slv_clr) begin
            slv_wait <= 0;
            slv_idx  <= 0;
            log_adr.delete();
            log_dat.delete();
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (stb && (ack || berr)) begin
            slv_wait <= 0;
            slv_idx  <= slv_idx + 1;
            if (!berr) begin
                mem[adr[7:2]] <= dat_o;
                log_adr.push_back(adr);
                log_dat.push_back(dat_o);
            end
        end else if (stb) begin
            slv_wait <= slv_wait + 1;
        end else begin
            slv_wait <= 0;
        end
    end

    // Bus protocol monitor.
    int          mon_viol = 0;
    int          done_total = 0;
    int          stb_total = 0;
    logic        p_stb = 1'b0;
    logic [31:0] p_adr = 32'h0, p_dat = 32'h0;
    logic [3:0]  p_sel = 4'h0;

    always @(negedge clk) begin
        if (done) done_total <= done_total + 1;
        if (stb) stb_total <= stb_total + 1;
        if ((stb && (sel !== 4'hF || !cyc || !we)) ||
            (stb && p_stb && (adr !== p_adr || dat_o !== p_dat || sel !== p_sel)) ||
            (byte_ready && cyc) ||
            (!cyc && (stb || we || sel != 4'h0)))
            mon_viol <= mon_viol + 1;
        p_stb <= stb;
        p_adr <= adr;
        p_dat <= dat_o;
        p_sel <= sel;
    end

    logic [7:0] src[$];
    bit  r_ended, r_ready0, r_err0, r_cyc_err;
    int  r_first, r_done_at, r_err_at;

    task automatic setup_slave(input bit mute, input int dly, input int err_at);
        slv_mute   = mute;
        slv_delay  = dly;
        slv_err_at = err_at;
        slv_clr    = 1'b1;
        @(posedge clk); #1;
        slv_clr    = 1'b0;
    endtask

    // thr: 0 = valid held high, 1 = valid toggling, 2 = random valid.
    // Cycle t=0 is the cycle right after the start pulse is sampled.
    task automatic run_load(input int len, input int thr, input int max_cyc,
                            input int inj_a, input int inj_b);
        int idx;
        bit tog;
        idx = 0;
        tog = 1'b1;
        r_ended = 0; r_ready0 = 0; r_err0 = 0; r_cyc_err = 1;
        r_first = -1; r_done_at = -1; r_err_at = -1;
        @(posedge clk); #1;
        ld_start = 1'b1;
        ld_len   = len[AW:0];
        @(posedge clk); #1;
        ld_start = 1'b0;
        ld_len   = 7'(len + 3);
        for (int t = 0; t < max_cyc && !r_ended; t++) begin
            ld_start = (t == inj_a) || (t == inj_b);
            if (idx < src.size() &&
                (thr == 0 || (thr == 1 && tog) || (thr == 2 && $urandom_range(0, 1) == 1))) begin
                byte_valid = 1'b1;
                byte_d     = src[idx];
            end else begin
                byte_valid = 1'b0;
                byte_d     = 8'($urandom);
            end
            tog = !tog;
            @(negedge clk);
            if (t == 0) begin
                r_ready0 = byte_ready;
                r_err0   = err;
            end
            if (byte_valid && byte_ready) begin
                if (r_first < 0) r_first = t;
                idx++;
            end
            if (done && r_done_at < 0) r_done_at = t;
            if (err && r_err_at < 0) begin
                r_err_at  = t;
                r_cyc_err = cyc;
            end
            if (done || err) r_ended = 1;
            @(posedge clk); #1;
        end
        ld_start   = 1'b0;
        byte_valid = 1'b0;
        if (r_ended) begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_src(input int nbytes);
        src.delete();
        for (int i = 0; i < nbytes; i++) src.push_back(8'($urandom));
    endtask

    // Reference: word i is bytes 4i..4i+3 big-endian, written at BASE + 4i.
    task automatic verify(input string tag, input bit exp_done, input bit exp_err,
                          input int exp_wr, input int d0, input int v0);
        logic [31:0] w;
        check($sformatf("%s_ended", tag), 32'(r_ended), 32'd1);
        check($sformatf("%s_done_cnt", tag), done_total - d0, 32'(exp_done));
        check($sformatf("%s_err", tag), 32'(err), 32'(exp_err));
        check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s_cyc", tag), 32'(cyc), 32'd0);
        check($sformatf("%s_nwr", tag), log_adr.size(), exp_wr);
        for (int i = 0; i < exp_wr && i < log_adr.size(); i++) begin
            w = (32'(src[4*i]) << 24) | (32'(src[4*i+1]) << 16) |
                (32'(src[4*i+2]) << 8) | 32'(src[4*i+3]);
            check($sformatf("%s_adr%0d", tag, i), log_adr[i], BASE + 32'(4 * i));
            check($sformatf("%s_dat%0d", tag, i), log_dat[i], w);
            check($sformatf("%s_mem%0d", tag, i), mem[i], w);
        end
        check($sformatf("%s_protocol", tag), mon_viol - v0, 32'd0);
    endtask

    typedef struct {
        int len;
        int thr;
        int dly;
        int err_at;
        bit exp_done;
        bit exp_err;
        int exp_wr;
    } vec_t;

    vec_t vecs[8];

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_ready", tag), 32'(byte_ready), 32'd0);
        check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s_done", tag), 32'(done), 32'd0);
        check($sformatf("%s_err", tag), 32'(err), 32'd0);
        check($sformatf("%s_ctl", tag), {29'd0, cyc, stb, we}, 32'd0);
        check($sformatf("%s_sel", tag), 32'(sel), 32'd0);
        check($sformatf("%s_adr", tag), adr, 32'd0);
        check($sformatf("%s_dat", tag), dat_o, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, v0, s0;
        rst = 1'b1; ld_start = 1'b0; ld_len = '0; byte_d = 8'h0; byte_valid = 1'b0;
        dat_i = 32'hDEAD_BEEF; slv_clr = 1'b0; slv_mute = 1'b0; slv_delay = 0; slv_err_at = -1;

        vecs[0] = '{len: 1,  thr: 0, dly: 0, err_at: -1, exp_done: 1, exp_err: 0, exp_wr: 1};
        vecs[1] = '{len: 3,  thr: 1, dly: 3, err_at: -1, exp_done: 1, exp_err: 0, exp_wr: 3};
        vecs[2] = '{len: 4,  thr: 0, dly: 0, err_at: 2,  exp_done: 0, exp_err: 1, exp_wr: 2};
        vecs[3] = '{len: 2,  thr: 1, dly: 0, err_at: 0,  exp_done: 0, exp_err: 1, exp_wr: 0};
        vecs[4] = '{len: 5,  thr: 1, dly: 7, err_at: -1, exp_done: 1, exp_err: 0, exp_wr: 5};
        vecs[5] = '{len: 2,  thr: 0, dly: 8, err_at: -1, exp_done: 0, exp_err: 1, exp_wr: 0};
        vecs[6] = '{len: 64, thr: 0, dly: 0, err_at: -1, exp_done: 1, exp_err: 0, exp_wr: 64};
        vecs[7] = '{len: 6,  thr: 2, dly: 1, err_at: -1, exp_done: 1, exp_err: 0, exp_wr: 6};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Back-to-back len=2 load with single-cycle acks and timing checks.
        setup_slave(0, 0, -1);
        src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        d0 = done_total; v0 = mon_viol;
        run_load(2, 0, 60, -1, -1);
        check("basic_ready_latency", 32'(r_ready0), 32'd1);
        check("basic_done_delay", r_done_at - r_first, 32'd10);
        verify("basic", 1, 0, 2, d0, v0);
        check("basic_word0", log_dat.size() > 0 ? log_dat[0] : 32'h0, 32'h1122_3344);

        // Table-driven scenarios with random payloads.
        foreach (vecs[k]) begin
            setup_slave(0, vecs[k].dly, vecs[k].err_at);
            fill_src(vecs[k].len * 4);
            d0 = done_total; v0 = mon_viol;
            run_load(vecs[k].len, vecs[k].thr, 40 + vecs[k].len * 40, -1, -1);
            verify($sformatf("vec%0d", k), vecs[k].exp_done, vecs[k].exp_err,
                   vecs[k].exp_wr, d0, v0);
        end

        // Error on 3rd write, then a restart clears err_o and reloads from base.
        setup_slave(0, 0, 2);
        fill_src(16);
        d0 = done_total; v0 = mon_viol;
        run_load(4, 0, 200, -1, -1);
        verify("errload", 0, 1, 2, d0, v0);
        setup_slave(0, 0, -1);
        fill_src(4);
        d0 = done_total; v0 = mon_viol;
        run_load(1, 0, 60, -1, -1);
        check("restart_err_cleared", 32'(r_err0), 32'd0);
        verify("restart", 1, 0, 1, d0, v0);

        // Silent slave: stb high for exactly TMO cycles, then err with cyc low.
        setup_slave(1, 0, -1);
        fill_src(4);
        d0 = done_total; v0 = mon_viol; s0 = stb_total;
        run_load(1, 0, 60, -1, -1);
        check("tmo_stb_cycles", stb_total - s0, 32'(TMO));
        check("tmo_err_cycle", r_err_at, 32'(4 + TMO));
        check("tmo_cyc_at_err", 32'(r_cyc_err), 32'd0);
        verify("tmo", 0, 1, 0, d0, v0);

        // len=0: done the cycle after start and no bus activity.
        setup_slave(0, 0, -1);
        src.delete();
        d0 = done_total; v0 = mon_viol; s0 = stb_total;
        run_load(0, 0, 10, -1, -1);
        check("len0_done_cycle", r_done_at, 32'd0);
        check("len0_no_bus", stb_total - s0, 32'd0);
        verify("len0", 1, 0, 0, d0, v0);

        // Start pulses during COLLECT and during WRITE must be ignored.
        setup_slave(0, 0, -1);
        fill_src(12);
        d0 = done_total; v0 = mon_viol;
        run_load(2, 0, 60, 1, 4);
        verify("midstart", 1, 0, 2, d0, v0);

        // Reset in the middle of a write drops everything on the next edge.
        setup_slave(1, 0, -1);
        fill_src(4);
        run_load(1, 0, 6, -1, -1);
        check("rstmid_in_write", 32'(stb), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rstmid");
        rst = 1'b0;

        // Randomized loads against the reference.
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, 8);
            setup_slave(0, $urandom_range(0, 3), -1);
            fill_src(len * 4);
            d0 = done_total; v0 = mon_viol;
            run_load(len, 2, 40 + len * 40, -1, -1);
            verify($sformatf("rand%0d", k), 1, 0, len, d0, v0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
